// File: rtl/sent_pkg.sv
// Constants and helpers shared by the SENT transmit and receive paths.
// Holds the frame state encoding, period lengths and the CRC-4 lookup.
package sent_pkg;

    typedef logic [2:0] sent_state_t;

    localparam sent_state_t ST_IDLE   = 3'd0;
    localparam sent_state_t ST_SYNC   = 3'd1;
    localparam sent_state_t ST_STATUS = 3'd2;
    localparam sent_state_t ST_DATA   = 3'd3;
    localparam sent_state_t ST_CRC    = 3'd4;
    localparam sent_state_t ST_PAUSE  = 3'd5;

    localparam int SYNC_TICKS        = 56;
    localparam int NIBBLE_BASE_TICKS = 12;
    localparam int MIN_PAUSE_TICKS   = 12;

    localparam logic [3:0] CRC4_SEED = 4'h5;

    // Entry i sits at bits [4*i+3:4*i]; entry i is i*x^4 mod (x^4+x^3+x^2+1).
    localparam logic [63:0] CRC4_TABLE = {
        4'd5, 4'd8, 4'd2, 4'd15, 4'd11, 4'd6, 4'd12, 4'd1,
        4'd4, 4'd9, 4'd3, 4'd14, 4'd10, 4'd7, 4'd13, 4'd0
    };

    function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic [3:0] nib);
        return nib ^ CRC4_TABLE[{crc, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/sent_tx_crc4.sv
// Combinational SENT CRC-4 over six data nibbles plus one augmenting zero nibble.
module sent_tx_crc4
    import sent_pkg::*;
(
    input  logic [23:0] data_fast,
    output logic [3:0]  crc
);

    logic [3:0] acc;

    always_comb begin
        acc = CRC4_SEED;
        for (int i = 5; i >= 0; i--) begin
            acc = crc4_step(acc, data_fast[i*4 +: 4]);
        end
        crc = crc4_step(acc, 4'h0);
    end

endmodule

// File: rtl/sent_tx_frame_gen.sv
// SENT fast-channel frame transmitter: sync, status, six data nibbles, CRC.
// Define SENT_TX_PAUSE_EN to add a pause pulse padding frames to FRAME_TICKS.
//
// state  | meaning
// IDLE   | line high, frame_ready asserted, waiting for a frame
// SYNC   | 56-tick calibration pulse
// STATUS | status nibble pulse
// DATA   | data nibble pulses, idx 0..5, [23:20] first
// CRC    | CRC-4 nibble pulse
// PAUSE  | pad to FRAME_TICKS (SENT_TX_PAUSE_EN only)
module sent_tx_frame_gen
    import sent_pkg::*;
#(
    parameter int TICK_DIV    = 3,
    parameter int LOW_TICKS   = 5
`ifdef SENT_TX_PAUSE_EN
    ,
    parameter int FRAME_TICKS = 282
`endif
) (
    input  logic        clk_tx,
    input  logic        reset_tx,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic [3:0]  status_nibble,
    input  logic [23:0] data_fast,
    output logic        data_pulse,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);
    localparam logic [3:0]  LOW_LEN  = 4'(LOW_TICKS);
    localparam logic [5:0]  SYNC_LEN = 6'(SYNC_TICKS);
    localparam logic [5:0]  NIB_BASE = 6'(NIBBLE_BASE_TICKS);

    logic [2:0]  state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [5:0]  per_q, per_d;
    logic [3:0]  low_q, low_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  status_q, status_d;
    logic [23:0] data_q, data_d;
    logic        pulse_q, pulse_d;

    logic [3:0]  crc;
    logic        tick, period_end, frame_end, accept;
    logic [2:0]  sel_idx;
    logic [3:0]  next_nib;

`ifdef SENT_TX_PAUSE_EN
    // Counts ticks up through the frame, then counts the pause down.
    logic [9:0]  frame_cnt_q, frame_cnt_d;
    logic [9:0]  ticks_so_far;
`endif

    sent_tx_crc4 u_crc (
        .data_fast (data_q),
        .crc       (crc)
    );

    assign frame_ready = reset_tx && (state_q == ST_IDLE);
    assign accept      = frame_valid && frame_ready;
    assign busy        = (state_q != ST_IDLE);
    assign data_pulse  = pulse_q;
    assign tick        = busy && (div_q == DIV_LAST);

`ifdef SENT_TX_PAUSE_EN
    assign period_end   = tick && ((state_q == ST_PAUSE) ? (frame_cnt_q == 10'd1) : (per_q == 6'd1));
    assign frame_end    = period_end && (state_q == ST_PAUSE);
    assign ticks_so_far = frame_cnt_q + 10'd1;
`else
    assign period_end   = tick && (per_q == 6'd1);
    assign frame_end    = period_end && (state_q == ST_CRC);
`endif

    // A reset arriving mid-frame must not leak a completion strobe.
    assign frame_done = reset_tx && frame_end;

    // Nibble for the period that starts next: [23:20] from STATUS, idx+1 from DATA.
    assign sel_idx  = (state_q == ST_DATA) ? idx_q + 3'd1 : 3'd0;
    assign next_nib = 4'(data_q >> (5'd20 - {sel_idx, 2'b00}));

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        per_d    = per_q;
        low_d    = low_q;
        idx_d    = idx_q;
        status_d = status_q;
        data_d   = data_q;
        pulse_d  = pulse_q;
`ifdef SENT_TX_PAUSE_EN
        frame_cnt_d = frame_cnt_q;
`endif

        if (busy) begin
            div_d = tick ? 16'd0 : div_q + 16'd1;
        end

        if (tick) begin
            if (per_q != 6'd0) begin
                per_d = per_q - 6'd1;
            end
            if (low_q != 4'd0) begin
                low_d = low_q - 4'd1;
                if (low_q == 4'd1) begin
                    pulse_d = 1'b1;
                end
            end
`ifdef SENT_TX_PAUSE_EN
            frame_cnt_d = (state_q == ST_PAUSE) ? frame_cnt_q - 10'd1 : frame_cnt_q + 10'd1;
`endif
        end

        if (period_end) begin
            low_d   = LOW_LEN;
            pulse_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_SYNC;
                    div_d    = 16'd0;
                    per_d    = SYNC_LEN;
                    low_d    = LOW_LEN;
                    pulse_d  = 1'b0;
                    idx_d    = 3'd0;
                    status_d = status_nibble;
                    data_d   = data_fast;
`ifdef SENT_TX_PAUSE_EN
                    frame_cnt_d = 10'd0;
`endif
                end
            end
            ST_SYNC: begin
                if (period_end) begin
                    state_d = ST_STATUS;
                    per_d   = NIB_BASE + 6'(status_q);
                end
            end
            ST_STATUS: begin
                if (period_end) begin
                    state_d = ST_DATA;
                    per_d   = NIB_BASE + 6'(next_nib);
                end
            end
            ST_DATA: begin
                if (period_end) begin
                    if (idx_q == 3'd5) begin
                        state_d = ST_CRC;
                        per_d   = NIB_BASE + 6'(crc);
                    end else begin
                        idx_d = idx_q + 3'd1;
                        per_d = NIB_BASE + 6'(next_nib);
                    end
                end
            end
            ST_CRC: begin
`ifdef SENT_TX_PAUSE_EN
                if (period_end) begin
                    state_d = ST_PAUSE;
                    per_d   = 6'd0;
                    if (ticks_so_far > 10'(FRAME_TICKS - MIN_PAUSE_TICKS)) begin
                        frame_cnt_d = 10'(MIN_PAUSE_TICKS);
                    end else begin
                        frame_cnt_d = 10'(FRAME_TICKS) - ticks_so_far;
                    end
                end
`endif
            end
            ST_PAUSE: begin
            end
            default: state_d = ST_IDLE;
        endcase

        if (frame_end) begin
            state_d = ST_IDLE;
            per_d   = 6'd0;
            low_d   = 4'd0;
            idx_d   = 3'd0;
            pulse_d = 1'b1;
`ifdef SENT_TX_PAUSE_EN
            frame_cnt_d = 10'd0;
`endif
        end
    end

    always_ff @(posedge clk_tx) begin
        if (!reset_tx) begin
            state_q  <= ST_IDLE;
            div_q    <= 16'd0;
            per_q    <= 6'd0;
            low_q    <= 4'd0;
            idx_q    <= 3'd0;
            status_q <= 4'd0;
            data_q   <= 24'd0;
            pulse_q  <= 1'b1;
`ifdef SENT_TX_PAUSE_EN
            frame_cnt_q <= 10'd0;
`endif
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            per_q    <= per_d;
            low_q    <= low_d;
            idx_q    <= idx_d;
            status_q <= status_d;
            data_q   <= data_d;
            pulse_q  <= pulse_d;
`ifdef SENT_TX_PAUSE_EN
            frame_cnt_q <= frame_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_sent_tx_frame_gen.sv
// Bench for sent_tx_frame_gen: frames compared cycle by cycle against a period-list model.
// Honours SENT_TX_PAUSE_EN the same way the design does.
module tb_sent_tx_frame_gen;

    localparam int TD     = 2;
    localparam int LT     = 5;
    localparam int BUDGET = 4000;
`ifdef SENT_TX_PAUSE_EN
    localparam int FT     = 200;
`endif

    logic        clk_tx = 1'b0;
    logic        reset_tx;
    logic        frame_valid;
    logic        frame_ready;
    logic [3:0]  status_nibble;
    logic [23:0] data_fast;
    logic        data_pulse;
    logic        busy;
    logic        frame_done;

    always #5 clk_tx = ~clk_tx;

    sent_tx_frame_gen #(
        .TICK_DIV    (TD),
        .LOW_TICKS   (LT)
`ifdef SENT_TX_PAUSE_EN
        ,
        .FRAME_TICKS (FT)
`endif
    ) dut (
        .clk_tx        (clk_tx),
        .reset_tx      (reset_tx),
        .frame_valid   (frame_valid),
        .frame_ready   (frame_ready),
        .status_nibble (status_nibble),
        .data_fast     (data_fast),
        .data_pulse    (data_pulse),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    logic obs[$];
    logic exp_q[$];
    int   done_at, done_cnt, bad_busy, bad_ready;
    bit   timed_out;

    // CRC as polynomial long division of seed, data nibbles and a zero nibble.
    function automatic logic [3:0] model_crc(input logic [23:0] d);
        logic [4:0] r;
        logic [3:0] nib;
        r = 5'h05;
        for (int k = 0; k < 7; k++) begin
            if (k < 6) nib = d[23 - 4*k -: 4];
            else       nib = 4'h0;
            for (int b = 3; b >= 0; b--) begin
                r = {r[3:0], nib[b]};
                if (r[4]) r = r ^ 5'h1D;
            end
        end
        return r[3:0];
    endfunction

    task automatic build_expected(input logic [3:0] st, input logic [23:0] dat);
        int per[$];
        int total;
        per.push_back(56);
        per.push_back(12 + int'(st));
        for (int k = 0; k < 6; k++) per.push_back(12 + int'(dat[23 - 4*k -: 4]));
        per.push_back(12 + int'(model_crc(dat)));
`ifdef SENT_TX_PAUSE_EN
        total = 0;
        foreach (per[i]) total += per[i];
        per.push_back((total > FT - 12) ? 12 : FT - total);
`else
        total = 0;
`endif
        exp_q.delete();
        foreach (per[i]) begin
            for (int c = 0; c < per[i] * TD; c++) exp_q.push_back(c >= LT * TD);
        end
    endtask

    // Called on the negedge before the accepting posedge; records cycles 1..N.
    task automatic capture(input bit hold_valid, input bit scramble, input int stop_at);
        obs.delete();
        done_at   = 0;
        done_cnt  = 0;
        bad_busy  = 0;
        bad_ready = 0;
        timed_out = 1'b1;
        for (int c = 1; c <= BUDGET; c++) begin
            @(negedge clk_tx);
            obs.push_back(data_pulse);
            if (busy !== 1'b1) bad_busy++;
            if (frame_ready !== 1'b0) bad_ready++;
            if (frame_done === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
            end
            if (!hold_valid) frame_valid = 1'b0;
            if (scramble) begin
                status_nibble = 4'($urandom);
                data_fast     = 24'($urandom);
            end
            if (frame_done === 1'b1 || c == stop_at) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    function automatic int first_diff();
        int n = (obs.size() > exp_q.size()) ? obs.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i >= obs.size() || i >= exp_q.size() || obs[i] !== exp_q[i]) return i + 1;
        end
        return 0;
    endfunction

    task automatic test_reset();
        reset_tx    = 1'b0;
        frame_valid = 1'b1;
        repeat (3) @(negedge clk_tx);
        n_cmp++;
        if (data_pulse !== 1'b1) begin n_err++; $display("FAIL reset_pulse: data_pulse=%b expected 1", data_pulse); end
        n_cmp++;
        if (frame_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: frame_ready=%b expected 0", frame_ready); end
        n_cmp++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            n_err++; $display("FAIL reset_busy_done: busy=%b frame_done=%b expected 0 0", busy, frame_done);
        end
        frame_valid = 1'b0;
        reset_tx    = 1'b1;
        @(negedge clk_tx);
        n_cmp++;
        if (frame_ready !== 1'b1 || busy !== 1'b0 || data_pulse !== 1'b1) begin
            n_err++; $display("FAIL reset_release: ready=%b busy=%b pulse=%b expected 1 0 1", frame_ready, busy, data_pulse);
        end
    endtask

    task automatic test_frame(input string name, input logic [3:0] st, input logic [23:0] dat);
        int d;
        status_nibble = st;
        data_fast     = dat;
        frame_valid   = 1'b1;
        n_cmp++;
        if (frame_ready !== 1'b1) begin n_err++; $display("FAIL %s ready: frame_ready=%b expected 1", name, frame_ready); end
        build_expected(st, dat);
        capture(1'b0, 1'b0, 0);
        n_cmp++;
        if (timed_out) begin n_err++; $display("FAIL %s timeout: no frame_done within %0d cycles, expected at %0d", name, BUDGET, exp_q.size()); end
        n_cmp++;
        if (done_at != exp_q.size()) begin n_err++; $display("FAIL %s done_cycle: frame_done at %0d expected %0d", name, done_at, exp_q.size()); end
        n_cmp++;
        if (done_cnt != 1) begin n_err++; $display("FAIL %s done_count: %0d pulses expected 1", name, done_cnt); end
        d = first_diff();
        n_cmp++;
        if (d != 0) begin
            n_err++; $display("FAIL %s waveform: first differing cycle %0d, len %0d expected %0d", name, d, obs.size(), exp_q.size());
        end
        n_cmp++;
        if (bad_busy != 0 || bad_ready != 0) begin
            n_err++; $display("FAIL %s busy_ready: %0d cycles busy low, %0d cycles ready high, expected 0 0", name, bad_busy, bad_ready);
        end
        @(negedge clk_tx);
        n_cmp++;
        if (busy !== 1'b0 || data_pulse !== 1'b1 || frame_ready !== 1'b1) begin
            n_err++; $display("FAIL %s after: busy=%b pulse=%b ready=%b expected 0 1 1", name, busy, data_pulse, frame_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  st;
        logic [23:0] dat;
        int          d;
        for (int k = 0; k < 3; k++) begin
            st            = 4'($urandom);
            dat           = 24'($urandom);
            status_nibble = st;
            data_fast     = dat;
            frame_valid   = 1'b1;
            n_cmp++;
            if (frame_ready !== 1'b1) begin n_err++; $display("FAIL b2b%0d ready_idle: frame_ready=%b expected 1", k, frame_ready); end
            build_expected(st, dat);
            capture(1'b1, 1'b1, 0);
            n_cmp++;
            if (done_at != exp_q.size()) begin n_err++; $display("FAIL b2b%0d done_cycle: frame_done at %0d expected %0d", k, done_at, exp_q.size()); end
            d = first_diff();
            n_cmp++;
            if (d != 0) begin n_err++; $display("FAIL b2b%0d waveform: first differing cycle %0d", k, d); end
            n_cmp++;
            if (bad_ready != 0 || bad_busy != 0) begin
                n_err++; $display("FAIL b2b%0d busy_ready: %0d ready-high, %0d busy-low cycles, expected 0 0", k, bad_ready, bad_busy);
            end
            if (k == 2) frame_valid = 1'b0;
            @(negedge clk_tx);
            n_cmp++;
            if (busy !== 1'b0 || data_pulse !== 1'b1) begin
                n_err++; $display("FAIL b2b%0d gap: busy=%b pulse=%b expected 0 1", k, busy, data_pulse);
            end
        end
        @(negedge clk_tx);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_stop: busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0]  st;
        logic [23:0] dat;
        int          start, bad, d;
        st    = 4'($urandom);
        dat   = 24'($urandom);
        start = 56 + 12 + int'(st);
        for (int k = 0; k < 3; k++) start += 12 + int'(dat[23 - 4*k -: 4]);
        status_nibble = st;
        data_fast     = dat;
        frame_valid   = 1'b1;
        build_expected(st, dat);
        capture(1'b0, 1'b0, (start + 2) * TD + 1);
        bad = 0;
        foreach (obs[i]) if (obs[i] !== exp_q[i]) bad++;
        n_cmp++;
        if (bad != 0 || obs.size() != (start + 2) * TD + 1) begin
            n_err++; $display("FAIL midrst_prefix: %0d bad cycles over %0d, expected 0 over %0d", bad, obs.size(), (start + 2) * TD + 1);
        end
        reset_tx = 1'b0;
        n_cmp++;
        if (done_cnt != 0 || frame_done !== 1'b0) begin
            n_err++; $display("FAIL midrst_no_done: %0d pulses, frame_done=%b expected 0 0", done_cnt, frame_done);
        end
        @(negedge clk_tx);
        n_cmp++;
        if (data_pulse !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
            n_err++; $display("FAIL midrst_state: pulse=%b busy=%b done=%b expected 1 0 0", data_pulse, busy, frame_done);
        end
        st            = 4'($urandom);
        dat           = 24'($urandom);
        status_nibble = st;
        data_fast     = dat;
        frame_valid   = 1'b1;
        @(negedge clk_tx);
        n_cmp++;
        if (frame_ready !== 1'b0) begin n_err++; $display("FAIL midrst_ready: frame_ready=%b expected 0", frame_ready); end
        reset_tx = 1'b1;
        build_expected(st, dat);
        capture(1'b0, 1'b0, 0);
        d = first_diff();
        n_cmp++;
        if (d != 0 || done_at != exp_q.size()) begin
            n_err++; $display("FAIL midrst_next: first diff %0d, done at %0d expected 0 and %0d", d, done_at, exp_q.size());
        end
        @(negedge clk_tx);
    endtask

    task automatic test_idle();
        int bad = 0;
        frame_valid = 1'b0;
        repeat (1000) begin
            @(negedge clk_tx);
            if (data_pulse !== 1'b1 || frame_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL idle_hold: %0d bad cycles of 1000, expected 0", bad); end
    endtask

    initial begin
        reset_tx      = 1'b0;
        frame_valid   = 1'b0;
        status_nibble = 4'h0;
        data_fast     = 24'h0;
        test_reset();
        test_frame("zero", 4'h0, 24'h000000);
        test_frame("incr", 4'hA, 24'h123456);
        test_frame("ones", 4'hF, 24'hFFFFFF);
        for (int i = 0; i < 5; i++) test_frame("rand", 4'($urandom), 24'($urandom));
        test_back_to_back();
        test_reset_mid_frame();
        test_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
